// File: rtl/trig_dly_pkg.sv
// Shared types and helpers for the trigger latency delay line.
package trig_dly_pkg;

  localparam int LEGACY_DLY = 28;
  localparam int FILL_W     = 16;

  // Wide enough for any practical DEPTH; saturates at DEPTH in the top.
  typedef logic [FILL_W-1:0] fill_cnt_t;

  function automatic int dly_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/trig_dly_ram.sv
// WIDTH x DEPTH simple dual-port history store: synchronous write, registered read.
module trig_dly_ram #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/trig_latency_delay_line.sv
// Multi-channel trigger delay line, effective delay E = DlyCur + Sel, history in a circular RAM.
// Optional per-channel minimum-pulse stretcher enabled by `define TRIGDLY_STRETCH_EN.
module trig_latency_delay_line
  import trig_dly_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int DEPTH       = 64,
  parameter int DLY_DEFAULT = LEGACY_DLY,
  parameter int MIN_PULSE   = 4
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [WIDTH-1:0]          Din,
  input  logic                      Sel,
  input  logic [dly_w(DEPTH)-1:0]   DlyIn,
  input  logic                      DlyLoad,
  output logic [WIDTH-1:0]          Dout,
  output logic [dly_w(DEPTH)-1:0]   DlyCur,
  output logic                      Ready,
  output logic                      DlyErr
);

  localparam int DLY_W = dly_w(DEPTH);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW    = AW + 2;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_addr;
  logic [SW-1:0]    rd_sum;
  logic [DLY_W-1:0] dly_cur_q, dly_cur_d;
  logic [DLY_W-1:0] eff_dly_q, eff_dly_d;
  logic             dly_err_q, dly_err_d;
  fill_cnt_t        fill_q, fill_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] ram_rdata;
  logic [WIDTH-1:0] tap_data;
  logic [WIDTH-1:0] raw_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    wr_ptr_d  = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    dly_cur_d = dly_cur_q;
    dly_err_d = 1'b0;
    if (DlyLoad) begin
      if (DlyIn == '0) begin
        dly_cur_d = DLY_W'(1);
        dly_err_d = 1'b1;
      end else if (DlyIn > DLY_W'(DEPTH - 1)) begin
        dly_cur_d = DLY_W'(DEPTH - 1);
        dly_err_d = 1'b1;
      end else begin
        dly_cur_d = DlyIn;
      end
    end
    // The read issued now feeds Dout one edge later, so it uses the delay that output will see.
    eff_dly_d = dly_cur_d + DLY_W'(Sel);
    rd_sum    = SW'(wr_ptr_d) + SW'(DEPTH + 1) - SW'(eff_dly_d);
    rd_addr   = (rd_sum >= SW'(DEPTH)) ? AW'(rd_sum - SW'(DEPTH)) : AW'(rd_sum);
  end

  always_comb begin
    din_d  = Din;
    fill_d = (fill_q == fill_cnt_t'(DEPTH)) ? fill_q : fill_q + fill_cnt_t'(1);
    ready_d = (fill_d >= fill_cnt_t'(eff_dly_q));
    // E=1 and E=2 are too short for the RAM's read register, so they come from Din / din_q.
    if (eff_dly_q == DLY_W'(1)) begin
      tap_data = Din;
    end else if (eff_dly_q == DLY_W'(2)) begin
      tap_data = din_q;
    end else begin
      tap_data = ram_rdata;
    end
    raw_d = ready_d ? tap_data : '0;
  end

  trig_dly_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (Clock),
    .wr_en   (!Reset),
    .wr_addr (wr_ptr_q),
    .wr_data (Din),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata)
  );

`ifdef TRIGDLY_STRETCH_EN
  localparam int PW   = (MIN_PULSE > 0) ? $clog2(MIN_PULSE + 1) : 1;
  localparam int HOLD = (MIN_PULSE > 1) ? MIN_PULSE - 1 : 0;

  logic [WIDTH-1:0] raw_q;
  logic [WIDTH-1:0] held;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      raw_q <= '0;
    end else begin
      raw_q <= raw_d;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stretch
    logic [PW-1:0] hold_q, hold_d;

    always_comb begin
      hold_d = hold_q;
      if (raw_d[gi] && !raw_q[gi]) begin
        hold_d = PW'(HOLD);
      end else if (hold_q != '0) begin
        hold_d = hold_q - PW'(1);
      end
    end

    always_ff @(posedge Clock) begin
      if (Reset) begin
        hold_q <= '0;
      end else begin
        hold_q <= hold_d;
      end
    end

    assign held[gi] = (hold_q != '0);
  end

  always_comb dout_d = raw_d | held;
`else
  always_comb dout_d = raw_d;

  // MIN_PULSE only sizes the stretch counters, which this build does not contain.
  if (MIN_PULSE < 0) begin : g_min_pulse_unused
  end
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q  <= '0;
      dly_cur_q <= DLY_W'(DLY_DEFAULT);
      eff_dly_q <= DLY_W'(DLY_DEFAULT) + DLY_W'(Sel);
      dly_err_q <= 1'b0;
      fill_q    <= '0;
      ready_q   <= 1'b0;
      dout_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      dly_cur_q <= dly_cur_d;
      eff_dly_q <= eff_dly_d;
      dly_err_q <= dly_err_d;
      fill_q    <= fill_d;
      ready_q   <= ready_d;
      dout_q    <= dout_d;
    end
    din_q <= din_d;
  end

  assign Dout   = dout_q;
  assign DlyCur = dly_cur_q;
  assign Ready  = ready_q;
  assign DlyErr = dly_err_q;

endmodule
